// File: rtl/fpsub_seq.sv
// fpsub_seq: multi-cycle binary32 subtractor, s = a - b.
// Alignment and normalization shift one bit per cycle.
// Optional feature: define FPSUB_RNE_EN to get round-to-nearest-even. Without it,
// results are truncated and overflow saturates to the largest finite value.
// Denormal inputs and underflowing results are flushed to signed zero.
module fpsub_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] s,
    output logic        invalid
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_ALIGN = 3'd2,
        S_ADD   = 3'd3,
        S_NORM  = 3'd4,
        S_ROUND = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    state_t state_q, state_d;

    // Captured operands; sb_q already holds the flipped sign of b.
    logic        sa_q, sa_d, sb_q, sb_d;
    logic [7:0]  ea_q, ea_d, eb_q, eb_d;
    logic [22:0] fa_q, fa_d, fb_q, fb_d;

    // Working datapath: result sign/exponent, larger and smaller 27-bit mantissas.
    // Mantissa layout: [26] hidden bit, [25:3] fraction, [2] guard, [1] round, [0] sticky.
    logic        sign_q, sign_d;
    logic [8:0]  exp_q, exp_d;
    logic [26:0] mbig_q, mbig_d;
    logic [26:0] msml_q, msml_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        sub_q, sub_d;
    logic        zero_q, zero_d;
    logic        flush_q, flush_d;

    // Result registers, loaded only on entry to DONE.
    logic [31:0] s_q, s_d;
    logic        inv_q, inv_d;

    // Operand classification and special-case result.
    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic        chk_special;
    logic [31:0] spec_res;
    logic        spec_inv;
    logic        a_ge_b;
    logic [7:0]  e_big, e_sml, e_diff;
    logic [22:0] f_big, f_sml;

    // Add/normalize/round helpers.
    logic [27:0] sum;
    logic        norm_exit;
    logic [23:0] mant24;
    logic        rnd_inc;
    logic [24:0] mant25;
    logic [8:0]  exp_r;
    logic [22:0] frac_r;
    logic [31:0] rnd_res;

    // Classify captured operands and build the special-case result.
    always_comb begin
        a_nan  = (ea_q == 8'hFF) && (fa_q != 23'd0);
        b_nan  = (eb_q == 8'hFF) && (fb_q != 23'd0);
        a_inf  = (ea_q == 8'hFF) && (fa_q == 23'd0);
        b_inf  = (eb_q == 8'hFF) && (fb_q == 23'd0);
        a_zero = (ea_q == 8'd0);
        b_zero = (eb_q == 8'd0);
        chk_special = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;
        spec_res = 32'd0;
        spec_inv = 1'b0;
        if (a_nan || b_nan) begin
            spec_res = QNAN;
            spec_inv = 1'b1;
        end else if (a_inf && b_inf) begin
            // Opposite effective signs means inf - inf of like-signed operands.
            if (sa_q != sb_q) begin
                spec_res = QNAN;
                spec_inv = 1'b1;
            end else begin
                spec_res = {sa_q, 8'hFF, 23'd0};
            end
        end else if (a_inf) begin
            spec_res = {sa_q, 8'hFF, 23'd0};
        end else if (b_inf) begin
            spec_res = {sb_q, 8'hFF, 23'd0};
        end else if (a_zero && b_zero) begin
            // Only (-0) - (+0) keeps the negative sign.
            spec_res = {sa_q & sb_q, 31'd0};
        end else if (a_zero) begin
            spec_res = {sb_q, eb_q, fb_q};
        end else begin
            spec_res = {sa_q, ea_q, fa_q};
        end

        a_ge_b = {ea_q, fa_q} >= {eb_q, fb_q};
        e_big  = a_ge_b ? ea_q : eb_q;
        e_sml  = a_ge_b ? eb_q : ea_q;
        f_big  = a_ge_b ? fa_q : fb_q;
        f_sml  = a_ge_b ? fb_q : fa_q;
        e_diff = e_big - e_sml;
    end

    // Mantissa add/subtract, normalization exit test and rounding/packing.
    always_comb begin
        if (sub_q) begin
            sum = {1'b0, mbig_q} - {1'b0, msml_q};
        end else begin
            sum = {1'b0, mbig_q} + {1'b0, msml_q};
        end

        norm_exit = zero_q | mbig_q[26] | (exp_q == 9'd1) | mbig_q[25];

        mant24 = mbig_q[26:3];
`ifdef FPSUB_RNE_EN
        rnd_inc = mbig_q[2] & (mbig_q[1] | mbig_q[0] | mant24[0]);
`else
        rnd_inc = 1'b0;
`endif
        mant25 = {1'b0, mant24} + {24'd0, rnd_inc};
        exp_r  = exp_q + {8'd0, mant25[24]};
        frac_r = mant25[24] ? mant25[23:1] : mant25[22:0];

        if (zero_q) begin
            rnd_res = 32'd0;
        end else if (flush_q) begin
            rnd_res = {sign_q, 31'd0};
        end else if (exp_r >= 9'd255) begin
`ifdef FPSUB_RNE_EN
            rnd_res = {sign_q, 8'hFF, 23'd0};
`else
            rnd_res = {sign_q, 8'hFE, 23'h7F_FFFF};
`endif
        end else begin
            rnd_res = {sign_q, exp_r[7:0], frac_r};
        end
    end

    // Datapath next-state: each FSM state advances its own piece of the operation.
    always_comb begin
        sa_d    = sa_q;
        sb_d    = sb_q;
        ea_d    = ea_q;
        eb_d    = eb_q;
        fa_d    = fa_q;
        fb_d    = fb_q;
        sign_d  = sign_q;
        exp_d   = exp_q;
        mbig_d  = mbig_q;
        msml_d  = msml_q;
        cnt_d   = cnt_q;
        sub_d   = sub_q;
        zero_d  = zero_q;
        flush_d = flush_q;
        s_d     = s_q;
        inv_d   = inv_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sa_d    = a[31];
                    ea_d    = a[30:23];
                    fa_d    = a[22:0];
                    sb_d    = ~b[31];
                    eb_d    = b[30:23];
                    fb_d    = b[22:0];
                    zero_d  = 1'b0;
                    flush_d = 1'b0;
                end
            end
            S_CHECK: begin
                if (chk_special) begin
                    s_d   = spec_res;
                    inv_d = spec_inv;
                end else begin
                    sign_d = a_ge_b ? sa_q : sb_q;
                    exp_d  = {1'b0, e_big};
                    mbig_d = {1'b1, f_big, 3'b000};
                    msml_d = {1'b1, f_sml, 3'b000};
                    // Beyond 26 shifts the smaller operand is already pure sticky.
                    cnt_d  = (e_diff > 8'd26) ? 5'd26 : e_diff[4:0];
                    sub_d  = sa_q ^ sb_q;
                end
            end
            S_ALIGN: begin
                msml_d = {1'b0, msml_q[26:2], msml_q[1] | msml_q[0]};
                cnt_d  = cnt_q - 5'd1;
            end
            S_ADD: begin
                if (sum == 28'd0) begin
                    zero_d = 1'b1;
                    sign_d = 1'b0;
                    mbig_d = 27'd0;
                end else if (sum[27]) begin
                    mbig_d = {sum[27:2], sum[1] | sum[0]};
                    exp_d  = exp_q + 9'd1;
                end else begin
                    mbig_d = sum[26:0];
                end
            end
            S_NORM: begin
                if (!zero_q && !mbig_q[26]) begin
                    if (exp_q == 9'd1) begin
                        flush_d = 1'b1;
                    end else begin
                        mbig_d = {mbig_q[25:0], 1'b0};
                        exp_d  = exp_q - 9'd1;
                    end
                end
            end
            S_ROUND: begin
                s_d   = rnd_res;
                inv_d = 1'b0;
            end
            default: ;
        endcase
    end

    // Datapath and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            ea_q    <= 8'd0;
            eb_q    <= 8'd0;
            fa_q    <= 23'd0;
            fb_q    <= 23'd0;
            sign_q  <= 1'b0;
            exp_q   <= 9'd0;
            mbig_q  <= 27'd0;
            msml_q  <= 27'd0;
            cnt_q   <= 5'd0;
            sub_q   <= 1'b0;
            zero_q  <= 1'b0;
            flush_q <= 1'b0;
            s_q     <= 32'd0;
            inv_q   <= 1'b0;
        end else begin
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            ea_q    <= ea_d;
            eb_q    <= eb_d;
            fa_q    <= fa_d;
            fb_q    <= fb_d;
            sign_q  <= sign_d;
            exp_q   <= exp_d;
            mbig_q  <= mbig_d;
            msml_q  <= msml_d;
            cnt_q   <= cnt_d;
            sub_q   <= sub_d;
            zero_q  <= zero_d;
            flush_q <= flush_d;
            s_q     <= s_d;
            inv_q   <= inv_d;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_CHECK;
            S_CHECK: begin
                if (chk_special) begin
                    state_d = S_DONE;
                end else if (ea_q == eb_q) begin
                    state_d = S_ADD;
                end else begin
                    state_d = S_ALIGN;
                end
            end
            S_ALIGN: if (cnt_q == 5'd1) state_d = S_ADD;
            S_ADD:   state_d = S_NORM;
            S_NORM:  if (norm_exit) state_d = S_ROUND;
            S_ROUND: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        busy    = (state_q != S_IDLE);
        done    = (state_q == S_DONE);
        s       = s_q;
        invalid = inv_q;
    end

endmodule
